// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: big-endian byte/half/word accesses over a single-outstanding
// req/ack bus, with pipeline stall while the access is in flight and an ack timeout.
module mem_lsu #(
    parameter int ACK_WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic        whilo_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_data_o,
    input  logic [31:0] bus_data_i,
    input  logic        bus_ack_i,
    output logic        stallreq_o,
    output logic        addr_err_o,
    output logic        bus_err_o
);

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic [4:0] NOP_REG_ADDR = 5'b00000;
    // The counter value on the last BUSY cycle before giving up: BUSY lasts ACK_WAIT_MAX cycles.
    localparam logic [7:0] WAIT_LIMIT   = 8'(ACK_WAIT_MAX - 1);

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  wait_cnt;
    logic [31:0] rdata_p1;

    logic        is_load;
    logic        is_store;
    logic        is_mem;
    logic [1:0]  size;
    logic        misaligned;
    logic        start;
    logic        ack_timeout;

    function automatic logic [3:0] lane_sel(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] sel;
        case (sz)
            SZ_BYTE: sel = 4'b1000 >> off;
            SZ_HALF: sel = off[1] ? 4'b0011 : 4'b1100;
            default: sel = 4'b1111;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] src);
        logic [31:0] d;
        case (sz)
            SZ_BYTE: d = {4{src[7:0]}};
            SZ_HALF: d = {2{src[15:0]}};
            default: d = src;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extract(input logic [7:0] op, input logic [1:0] off,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (op)
            EXE_LB_OP:  r = {{24{b[7]}}, b};
            EXE_LBU_OP: r = {24'h000000, b};
            EXE_LH_OP:  r = {{16{h[15]}}, h};
            EXE_LHU_OP: r = {16'h0000, h};
            default:    r = word;
        endcase
        return r;
    endfunction

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        size     = SZ_WORD;
        case (aluop_i)
            EXE_LB_OP, EXE_LBU_OP: begin is_load  = 1'b1; size = SZ_BYTE; end
            EXE_LH_OP, EXE_LHU_OP: begin is_load  = 1'b1; size = SZ_HALF; end
            EXE_LW_OP:             begin is_load  = 1'b1; size = SZ_WORD; end
            EXE_SB_OP:             begin is_store = 1'b1; size = SZ_BYTE; end
            EXE_SH_OP:             begin is_store = 1'b1; size = SZ_HALF; end
            EXE_SW_OP:             begin is_store = 1'b1; size = SZ_WORD; end
            default:               ;
        endcase
    end

    assign is_mem      = is_load | is_store;
    assign misaligned  = is_mem && (((size == SZ_HALF) && mem_addr_i[0]) ||
                                    ((size == SZ_WORD) && (mem_addr_i[1:0] != 2'b00)));
    assign start       = is_mem && !misaligned && (state == IDLE);
    assign ack_timeout = (wait_cnt == WAIT_LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stage boundary: bus request registers and load-data latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_req_o  <= 1'b0;
            bus_we_o   <= 1'b0;
            bus_addr_o <= 32'h0;
            bus_sel_o  <= 4'h0;
            bus_data_o <= 32'h0;
            bus_err_o  <= 1'b0;
            rdata_p1   <= 32'h0;
            wait_cnt   <= 8'h0;
        end else begin
            bus_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bus_req_o  <= 1'b1;
                        bus_we_o   <= is_store;
                        bus_addr_o <= {mem_addr_i[31:2], 2'b00};
                        bus_sel_o  <= lane_sel(size, mem_addr_i[1:0]);
                        bus_data_o <= store_data(size, reg2_i);
                        wait_cnt   <= 8'h0;
                    end
                end
                BUSY: begin
                    if (bus_ack_i) begin
                        bus_req_o <= 1'b0;
                        rdata_p1  <= bus_data_i;
                    end else if (ack_timeout) begin
                        bus_req_o <= 1'b0;
                        bus_err_o <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state;
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = wdata_i;
        whilo_o    = whilo_i;
        hi_o       = hi_i;
        lo_o       = lo_i;
        stallreq_o = 1'b0;
        addr_err_o = 1'b0;

        case (state)
            IDLE:    if (start) state_nxt = BUSY;
            BUSY:    if (bus_ack_i || ack_timeout) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase

        if (!rst) begin
            wd_o    = NOP_REG_ADDR;
            wreg_o  = 1'b0;
            wdata_o = 32'h0;
            whilo_o = 1'b0;
            hi_o    = 32'h0;
            lo_o    = 32'h0;
        end else if (misaligned) begin
            addr_err_o = 1'b1;
            wreg_o     = 1'b0;
        end else if (is_mem) begin
            if (state == DONE) begin
                // bus_err_o is high exactly in the DONE cycle of an abandoned access
                wreg_o = wreg_i && !bus_err_o;
                if (is_load) wdata_o = load_extract(aluop_i, mem_addr_i[1:0], rdata_p1);
            end else begin
                stallreq_o = 1'b1;
                wreg_o     = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: stimulus pushes expected retire values into a scoreboard,
// a monitor pops them whenever an active instruction leaves MEM (stallreq_o low).
module tb_mem_lsu;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_ADDU = 8'b0010_0001;
    localparam logic [7:0] OP_LB   = 8'b1110_0000;
    localparam logic [7:0] OP_LBU  = 8'b1110_0100;
    localparam logic [7:0] OP_LH   = 8'b1110_0001;
    localparam logic [7:0] OP_LHU  = 8'b1110_0101;
    localparam logic [7:0] OP_LW   = 8'b1110_0011;
    localparam logic [7:0] OP_SB   = 8'b1110_1000;
    localparam logic [7:0] OP_SW   = 8'b1110_1011;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic        whilo_i;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_data_o;
    logic [31:0] bus_data_i;
    logic        bus_ack_i;
    logic        stallreq_o;
    logic        addr_err_o;
    logic        bus_err_o;

    mem_lsu dut (
        .clk(clk), .rst(rst),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .whilo_i(whilo_i),
        .hi_i(hi_i), .lo_i(lo_i), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
        .hi_o(hi_o), .lo_o(lo_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_sel_o(bus_sel_o), .bus_data_o(bus_data_o),
        .bus_data_i(bus_data_i), .bus_ack_i(bus_ack_i),
        .stallreq_o(stallreq_o), .addr_err_o(addr_err_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] lo;
        logic        aerr;
        logic        berr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic active = 1'b0;

    // bus responder configuration
    int          ack_delay = 0;
    logic        ack_en = 1'b1;
    logic        spurious = 1'b0;
    logic [31:0] rdata = 32'h0;

    // per-op observations
    int          stall_cnt;
    logic        snap_valid;
    logic        snap_we;
    logic [3:0]  snap_sel;
    logic [31:0] snap_addr;
    logic [31:0] snap_data;
    logic        done_req;
    logic        post_req;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    initial begin
        int req_cyc;
        req_cyc = 0;
        bus_ack_i = 1'b0;
        bus_data_i = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (rst && bus_req_o) begin
                bus_ack_i  = ack_en && (req_cyc == ack_delay);
                bus_data_i = rdata;
                req_cyc++;
            end else begin
                bus_ack_i = spurious;
                bus_data_i = 32'hBAD0BAD0;
                req_cyc = 0;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (active && rst && !stallreq_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow actual=retire required=none");
                end else begin
                    e = sb.pop_front();
                    chk("ret_wd", 32'(wd_o), 32'(e.wd));
                    chk("ret_wreg", 32'(wreg_o), 32'(e.wreg));
                    chk("ret_wdata", wdata_o, e.wdata);
                    chk("ret_lo", lo_o, e.lo);
                    chk("ret_addr_err", 32'(addr_err_o), 32'(e.aerr));
                    chk("ret_bus_err", 32'(bus_err_o), 32'(e.berr));
                end
            end
        end
    end

    task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                          input logic [31:0] wdin, input logic [4:0] wd, input logic wreg,
                          input logic [31:0] exp_wdata, input logic exp_wreg,
                          input logic exp_aerr, input logic exp_berr);
        exp_t e;
        int   n;
        logic go;
        e.wd = wd; e.wreg = exp_wreg; e.wdata = exp_wdata; e.lo = wdin ^ 32'h5A5A5A5A;
        e.aerr = exp_aerr; e.berr = exp_berr;
        sb.push_back(e);
        aluop_i = op; mem_addr_i = addr; reg2_i = r2; wdata_i = wdin;
        wd_i = wd; wreg_i = wreg; lo_i = wdin ^ 32'h5A5A5A5A; hi_i = ~wdin; whilo_i = 1'b0;
        active = 1'b1;
        stall_cnt = 0; snap_valid = 1'b0; n = 0; go = 1'b1;
        while (go) begin
            @(negedge clk);
            if (!stallreq_o) begin
                go = 1'b0;
            end else begin
                stall_cnt++;
                if (bus_req_o && !snap_valid) begin
                    snap_valid = 1'b1; snap_we = bus_we_o; snap_sel = bus_sel_o;
                    snap_addr = bus_addr_o; snap_data = bus_data_o;
                end
                n++;
                if (n > 2000) begin
                    $display("FAIL stall_bound actual=%0d required=<2000", n);
                    $fatal(1, "stall bound expired");
                end
            end
        end
        done_req = bus_req_o;
        @(posedge clk);
        #1;
        active = 1'b0;
        aluop_i = OP_NOP;
        post_req = bus_req_o;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        rst = 1'b0;
        aluop_i = OP_LW; mem_addr_i = 32'h1; reg2_i = 32'h0; wdata_i = 32'h55;
        wd_i = 5'd3; wreg_i = 1'b1; whilo_i = 1'b1; hi_i = 32'h11; lo_i = 32'h22;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wd", 32'(wd_o), 32'h0);
        chk("rst_wreg", 32'(wreg_o), 32'h0);
        chk("rst_wdata", wdata_o, 32'h0);
        chk("rst_hi", hi_o, 32'h0);
        chk("rst_stall", 32'(stallreq_o), 32'h0);
        chk("rst_addr_err", 32'(addr_err_o), 32'h0);
        chk("rst_bus_req", 32'(bus_req_o), 32'h0);
        chk("rst_bus_err", 32'(bus_err_o), 32'h0);
        aluop_i = OP_NOP;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // passthrough with a spurious ack present
        spurious = 1'b1;
        run_op(OP_ADDU, 32'h0, 32'h0, 32'h55, 5'd3, 1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
        spurious = 1'b0;
        chk("addu_stall", 32'(stall_cnt), 32'd0);
        chk("addu_no_req", 32'(post_req), 32'h0);

        ack_delay = 2; rdata = 32'hDEADBEEF;
        run_op(OP_LW, 32'h10, 32'h0, 32'h10, 5'd2, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
        chk("lw_stall", 32'(stall_cnt), 32'd4);
        chk("lw_sel", 32'(snap_sel), 32'hF);
        chk("lw_we", 32'(snap_we), 32'h0);
        chk("lw_addr", snap_addr, 32'h10);

        ack_delay = 0; rdata = 32'h12345680;
        run_op(OP_LB, 32'h3, 32'h0, 32'h3, 5'd4, 1'b1, 32'hFFFFFF80, 1'b1, 1'b0, 1'b0);
        chk("lb_sel", 32'(snap_sel), 32'h1);
        chk("lb_stall", 32'(stall_cnt), 32'd2);
        run_op(OP_LBU, 32'h3, 32'h0, 32'h3, 5'd5, 1'b1, 32'h00000080, 1'b1, 1'b0, 1'b0);

        rdata = 32'h12348000;
        run_op(OP_LH, 32'h2, 32'h0, 32'h2, 5'd6, 1'b1, 32'hFFFF8000, 1'b1, 1'b0, 1'b0);
        chk("lh_sel", 32'(snap_sel), 32'h3);
        rdata = 32'h80001234;
        run_op(OP_LHU, 32'h0, 32'h0, 32'h0, 5'd7, 1'b1, 32'h00008000, 1'b1, 1'b0, 1'b0);
        chk("lhu_sel", 32'(snap_sel), 32'hC);

        run_op(OP_SB, 32'h1, 32'hAB, 32'h1, 5'd0, 1'b0, 32'h1, 1'b0, 1'b0, 1'b0);
        chk("sb_we", 32'(snap_we), 32'h1);
        chk("sb_sel", 32'(snap_sel), 32'h4);
        chk("sb_data", snap_data, 32'hABABABAB);
        chk("sb_addr", snap_addr, 32'h0);

        run_op(OP_LH, 32'h5, 32'h0, 32'h5, 5'd8, 1'b1, 32'h5, 1'b0, 1'b1, 1'b0);
        chk("mis_stall", 32'(stall_cnt), 32'd0);
        chk("mis_req_done", 32'(done_req), 32'h0);
        chk("mis_req_after", 32'(post_req), 32'h0);

        run_op(OP_SW, 32'h20, 32'hCAFEF00D, 32'h20, 5'd0, 1'b0, 32'h20, 1'b0, 1'b0, 1'b0);
        chk("b2b_sw_stall", 32'(stall_cnt), 32'd2);
        chk("b2b_sw_data", snap_data, 32'hCAFEF00D);
        chk("b2b_sw_done_req", 32'(done_req), 32'h0);
        rdata = 32'h01020304;
        run_op(OP_LW, 32'h24, 32'h0, 32'h24, 5'd9, 1'b1, 32'h01020304, 1'b1, 1'b0, 1'b0);
        chk("b2b_lw_stall", 32'(stall_cnt), 32'd2);
        chk("b2b_lw_done_req", 32'(done_req), 32'h0);

        ack_en = 1'b0;
        run_op(OP_SW, 32'h30, 32'h77, 32'h30, 5'd0, 1'b0, 32'h30, 1'b0, 1'b0, 1'b1);
        chk("tmo_stall", 32'(stall_cnt), 32'd256);
        chk("tmo_req_done", 32'(done_req), 32'h0);
        chk("tmo_err_cleared", 32'(bus_err_o), 32'h0);
        ack_en = 1'b1;
        run_op(OP_ADDU, 32'h0, 32'h0, 32'h9, 5'd10, 1'b1, 32'h9, 1'b1, 1'b0, 1'b0);

        // asynchronous reset in the middle of an unacknowledged load
        ack_en = 1'b0;
        aluop_i = OP_LW; mem_addr_i = 32'h40; wd_i = 5'd4; wreg_i = 1'b1; wdata_i = 32'h40;
        @(posedge clk);
        #1;
        chk("rb_req_busy", 32'(bus_req_o), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("rb_req_async", 32'(bus_req_o), 32'h0);
        chk("rb_stall", 32'(stallreq_o), 32'h0);
        chk("rb_wd", 32'(wd_o), 32'h0);
        aluop_i = OP_NOP;
        @(posedge clk);
        #1;
        rst = 1'b1;
        ack_en = 1'b1;
        run_op(OP_ADDU, 32'h0, 32'h0, 32'h7, 5'd11, 1'b1, 32'h7, 1'b1, 1'b0, 1'b0);
        chk("rb_no_req", 32'(post_req), 32'h0);

        repeat (2) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- MEM-stage load/store unit. Consumes the registered EX/MEM outputs and performs byte, halfword and word loads and stores on the data bus.
- Uses a single-outstanding req/ack handshake and holds the pipeline through `stallreq_o` while a bus access is in flight.
- Passes non-memory results through to the MEM/WB register unchanged, and flags misaligned accesses.

Parameters:
- ACK_WAIT_MAX, 255: cycles in BUSY without ack before the access is abandoned with `bus_err_o`. Width of the wait counter is 8 bits.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset, asynchronous, active-low.
- wd_i  in  5  destination register from EX/MEM.
- wreg_i  in  1  register write enable from EX/MEM.
- wdata_i  in  32  ALU result from EX/MEM.
- whilo_i  in  1  HI/LO write enable from EX/MEM.
- hi_i  in  32  HI value from EX/MEM.
- lo_i  in  32  LO value from EX/MEM.
- aluop_i  in  8  operation code (`EXE_*_OP` from defines.v).
- mem_addr_i  in  32  effective address.
- reg2_i  in  32  store data source.
- wd_o  out  5  to MEM/WB.
- wreg_o  out  1  to MEM/WB.
- wdata_o  out  32  to MEM/WB.
- whilo_o  out  1  to MEM/WB.
- hi_o  out  32  to MEM/WB.
- lo_o  out  32  to MEM/WB.
- bus_req_o  out  1  bus request (registered).
- bus_we_o  out  1  1 = store (registered).
- bus_addr_o  out  32  word address, bits [1:0] forced to 0 (registered).
- bus_sel_o  out  4  byte lanes; bit3 = bits[31:24] (registered).
- bus_data_o  out  32  store data (registered).
- bus_data_i  in  32  load data.
- bus_ack_i  in  1  access complete, sampled only in BUSY.
- stallreq_o  out  1  stall request to ctrl.
- addr_err_o  out  1  misaligned access, combinational.
- bus_err_o  out  1  one-cycle pulse on ack timeout.

Behaviour:
- **Reset.** While `rst` = 0: state IDLE, all bus_* outputs 0, `bus_err_o` 0, read latch 0, wait counter 0. Combinational outputs also read as reset: `wd_o` = NOPRegAddr, `wreg_o`/`whilo_o` = 0, `wdata_o`/`hi_o`/`lo_o` = 0, `stallreq_o` = 0, `addr_err_o` = 0.
- **Byte order.** Big-endian. Address offset 0 maps to lane [31:24] and `sel` 4'b1000; offset 3 maps to [7:0] and 4'b0001.
- **Memory ops.** Memory ops are LB, LBU, LH, LHU, LW, SB, SH, SW. Any other aluop is a pure passthrough (all `*_o` = `*_i`), with `stallreq_o` = 0 and no bus activity.
- **Misaligned.** LH, LHU, SH with addr[0] = 1, or LW, SW with addr[1:0] ≠ 0, are misaligned. Response:
  - `addr_err_o` = 1, `wreg_o` = 0, no bus request, `stallreq_o` = 0.
  - The FSM stays IDLE.
- **Byte lanes and store data.**
  - SB: `sel` is a one-hot lane per addr[1:0]; data = {4{reg2[7:0]}}.
  - SH: `sel` = 1100 for addr[1] = 0, 0011 for addr[1] = 1; data = {2{reg2[15:0]}}.
  - SW: `sel` = 1111; data = reg2.
  - Loads use the same sel patterns as the stores of the same size, with `we` = 0.
- **State IDLE.** An aligned memory op drives `stallreq_o` = 1 combinationally. At the next edge: bus outputs are registered, `bus_req_o` = 1, wait counter cleared, go to BUSY.
- **State BUSY.**
  - `stallreq_o` = 1. EX/MEM holds its outputs, so the inputs are stable.
  - On an edge with `bus_ack_i` = 1: `bus_req_o` ← 0, read latch ← `bus_data_i`, go to DONE.
  - Otherwise the counter increments. When the counter reaches ACK_WAIT_MAX without ack: `bus_req_o` ← 0, `bus_err_o` pulses 1 for the DONE cycle, go to DONE with `wreg_o` suppressed.
- **State DONE.** `stallreq_o` = 0.
  - Loads: `wdata_o` = extracted lane from the latch. LB/LH sign-extend; LBU/LHU zero-extend; LW uses the whole word.
  - Stores: `wreg_o` = `wreg_i` (normally 0).
  - At the next edge the pipeline advances; return to IDLE unconditionally.
- **Minimum latency.** 3 cycles per access (IDLE, BUSY with immediate ack, DONE). Each extra wait cycle adds 1.
- **Back-to-back.** A memory op arriving right after DONE starts a fresh IDLE→BUSY sequence. No request is issued while in DONE.
- **Outputs outside DONE.** Until DONE, `wreg_o` = 0 for loads, so forwarding never sees stale load data.
- **Spurious ack.** `bus_ack_i` in IDLE or DONE is ignored.
- **Reset mid-access.** Asynchronous reset while in BUSY drops `bus_req_o` immediately. After reset, no completion is reported.

Test Plan:
- **LW with wait states.** LW at 0x00000010; ack asserted 2 cycles after req with data 0xDEADBEEF. Required: `bus_sel` = 1111, `stallreq` high 4 cycles, then DONE with `wdata_o` = 0xDEADBEEF, `wreg_o` = 1.
- **LB / LBU sign handling.** LB at 0x00000003, bus data 0x12345680. Required: `sel` = 0001, `wdata_o` = 0xFFFFFF80. Repeat with LBU. Required: 0x00000080.
- **SB lane replication.** SB at 0x00000001, reg2 = 0x000000AB. Required: `bus_we` = 1, `sel` = 0100, `bus_data_o` = 0xABABABAB, `bus_addr_o` = 0x00000000.
- **Misaligned LH.** LH at 0x00000005. Required: `addr_err_o` = 1, `wreg_o` = 0, `bus_req_o` stays 0, `stallreq_o` = 0.
- **Reset mid-BUSY.** Assert `rst` = 0 during BUSY. Required: `bus_req_o` falls without waiting for clk; after release, IDLE with a passthrough ADDU result (0x00000007) forwarded unchanged.
- **Back-to-back with timeout.** SW then LW, each acked immediately. Required: 3 cycles each, no overlapping req. Then SW with no ack. Required: after ACK_WAIT_MAX cycles, `bus_err_o` pulses 1 and the pipeline resumes.
